// File: rtl/tow_pkg.sv
// Shared types and 7-segment constants for the tug-of-war scoreboard.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package tow_pkg;

   typedef enum logic [1:0] {PLAY, HOLD, RESTART, DONE} tow_state_t;
   typedef enum logic [1:0] {WIN_NONE, WIN_P1, WIN_P2} tow_winner_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;

   localparam logic [3:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern; anything above 9 is blank.
module seg7_decode
   import tow_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/tow_scoreboard.sv
// Match scorekeeper: detects round wins from the end lights and presses,
// tallies scores, holds the winner on display, then re-centres the chain.
module tow_scoreboard
   import tow_pkg::*;
#(
   parameter int WIN_SCORE   = 3,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int HOLD_W      = 26
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       L,
   input  logic       R,
   input  logic       NL,
   input  logic       NR,
   output logic       round_rst,
   output logic       game_over,
   output logic [6:0] hex_p1,
   output logic [6:0] hex_p2,
   output logic [6:0] hex_winner
);

   localparam logic [3:0]        WIN_SCORE_4 = 4'(WIN_SCORE);
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);

   tow_state_t        state_q,    state_d;
   tow_winner_t       winner_q,   winner_d;
   logic [3:0]        score_p1_q, score_p1_d;
   logic [3:0]        score_p2_q, score_p2_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              p1_win, p2_win;
   logic [3:0]        new_score;
   logic [3:0]        winner_digit;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v >= 4'd9) ? 4'd9 : v + 4'd1;
   endfunction

   assign p1_win = NR & R;
   assign p2_win = NL & L;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= PLAY;
         winner_q   <= WIN_NONE;
         score_p1_q <= 4'd0;
         score_p2_q <= 4'd0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         score_p1_q <= score_p1_d;
         score_p2_q <= score_p2_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      score_p1_d = score_p1_q;
      score_p2_d = score_p2_q;
      hold_cnt_d = hold_cnt_q;
      new_score  = 4'd0;
      case (state_q)
         PLAY: begin
            // Both ends lit with simultaneous presses is an impossible board; ignore it.
            if (p1_win ^ p2_win) begin
               if (p1_win) begin
                  new_score  = sat_inc(score_p1_q);
                  score_p1_d = new_score;
                  winner_d   = WIN_P1;
               end else begin
                  new_score  = sat_inc(score_p2_q);
                  score_p2_d = new_score;
                  winner_d   = WIN_P2;
               end
               hold_cnt_d = '0;
               state_d    = (new_score == WIN_SCORE_4) ? DONE : HOLD;
            end
         end
         HOLD: begin
            if (hold_cnt_q == HOLD_LAST) state_d = RESTART;
            else                         hold_cnt_d = hold_cnt_q + 1'b1;
         end
         RESTART: begin
            state_d  = PLAY;
            winner_d = WIN_NONE;
         end
         DONE: state_d = DONE;
         default: state_d = PLAY;
      endcase
   end

   assign round_rst = (state_q == RESTART);
   assign game_over = (state_q == DONE);

   always_comb begin
      winner_digit = DIGIT_BLANK;
      if (state_q != PLAY) begin
         case (winner_q)
            WIN_P1:  winner_digit = 4'd1;
            WIN_P2:  winner_digit = 4'd2;
            default: winner_digit = DIGIT_BLANK;
         endcase
      end
   end

   seg7_decode u_dec_p1 (.digit(score_p1_q),   .seg(hex_p1));
   seg7_decode u_dec_p2 (.digit(score_p2_q),   .seg(hex_p2));
   seg7_decode u_dec_wn (.digit(winner_digit), .seg(hex_winner));

endmodule
